// File: rtl/cmp_sched_pkg.sv
// Shared types, result encodings and width helper for the serial compare scheduler.
package cmp_sched_pkg;

    // Sequencer states: capture in idle, one bit per shift cycle, one-cycle result.
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // One-hot result encodings, ordered {lt, eq, gt}.
    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_cmp_core.sv
// MSB-first bit-serial magnitude comparator.
// Ports:
//   clk_i, reset_i   clock, async active-high reset
//   load_i           capture a_i/b_i and start a compare
//   a_i, b_i         operands
//   busy_o           compare in progress
//   done_o           this cycle examines the final bit (combinational strobe)
//   lt_o, gt_o       decision including the current bit; valid while done_o is high
module serial_cmp_core
    import cmp_sched_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             lt_o,
    output logic             gt_o
);

    localparam int unsigned CW = id_width(WIDTH);

    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             dec_q, dec_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             a_bit, b_bit, differ;

    assign a_bit  = a_sh_q[WIDTH-1];
    assign b_bit  = b_sh_q[WIDTH-1];
    assign differ = a_bit ^ b_bit;
    assign busy_o = busy_q;

    // Once decided, later bits are ignored (only reachable with EARLY_EXIT=0).
    assign lt_o   = dec_q ? lt_q : (differ & b_bit);
    assign gt_o   = dec_q ? gt_q : (differ & a_bit);
    assign done_o = busy_q & ((EARLY_EXIT & differ) | (cnt_q == '0));

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        dec_d  = dec_q;
        lt_d   = lt_q;
        gt_d   = gt_q;
        if (load_i) begin
            a_sh_d = a_i;
            b_sh_d = b_i;
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
            dec_d  = 1'b0;
            lt_d   = 1'b0;
            gt_d   = 1'b0;
        end else if (busy_q) begin
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q << 1;
            cnt_d  = cnt_q - 1'b1;
            dec_d  = dec_q | differ;
            lt_d   = lt_o;
            gt_d   = gt_o;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dec_q  <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            dec_q  <= dec_d;
            lt_q   <= lt_d;
            gt_q   <= gt_d;
        end
    end

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin scheduler sharing one serial comparator among N_REQ requesters.
// Ports:
//   clk_i, reset_i           clock, async active-high reset
//   req_i                    per-requester level request, held until granted
//   a_in_i, b_in_i           packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt_o                    one-hot 1-cycle pulse: operands captured
//   busy_o                   shifting or presenting a result
//   res_valid_o              1-cycle pulse: result outputs are new
//   res_id_o                 requester owning the result
//   less_than_o, equal_to_o, greater_than_o   one-hot result, held until the next one
module serial_compare_scheduler
    import cmp_sched_pkg::*;
#(
    parameter  int unsigned WIDTH      = 4,
    parameter  int unsigned N_REQ      = 4,
    parameter  bit          EARLY_EXIT = 1'b1,
    localparam int unsigned IDW        = id_width(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] a_in_i,
    input  logic [N_REQ*WIDTH-1:0] b_in_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic                   busy_o,
    output logic                   res_valid_o,
    output logic [IDW-1:0]         res_id_o,
    output logic                   less_than_o,
    output logic                   equal_to_o,
    output logic                   greater_than_o
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       res_q, res_d;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    int unsigned      cand;
    logic             load;
    logic             core_busy, core_done, core_lt, core_gt;

    // First requesting index at or after the round-robin pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(rr_q) + i) % N_REQ;
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        id_d     = id_q;
        res_id_d = res_id_q;
        res_d    = res_q;
        gnt_d    = '0;
        load     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    load           = 1'b1;
                    gnt_d[win_idx] = 1'b1;
                    id_d           = win_idx;
                    state_d        = StShift;
                end
            end
            StShift: begin
                if (core_done) begin
                    state_d  = StDone;
                    res_id_d = id_q;
                    if (core_lt) begin
                        res_d = CMP_LT;
                    end else if (core_gt) begin
                        res_d = CMP_GT;
                    end else begin
                        res_d = CMP_EQ;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                rr_d    = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            id_q     <= '0;
            res_id_q <= '0;
            gnt_q    <= '0;
            res_q    <= CMP_EQ;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            res_id_q <= res_id_d;
            gnt_q    <= gnt_d;
            res_q    <= res_d;
        end
    end

    serial_cmp_core #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_core (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load),
        .a_i     (a_in_i[32'(win_idx)*WIDTH +: WIDTH]),
        .b_i     (b_in_i[32'(win_idx)*WIDTH +: WIDTH]),
        .busy_o  (core_busy),
        .done_o  (core_done),
        .lt_o    (core_lt),
        .gt_o    (core_gt)
    );

    assign gnt_o       = gnt_q;
    assign busy_o      = core_busy | (state_q == StDone);
    assign res_valid_o = (state_q == StDone);
    assign res_id_o    = res_id_q;
    assign {less_than_o, equal_to_o, greater_than_o} = res_q;

endmodule
